// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared definitions for the two-master on-chip memory arbiter: bus width defaults,
// requester ids, the read-tag entry layout and the round-robin pick.
package onchip_memory_arbiter_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = 4;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    // Returns {grant_m1, grant_m0}; on a tie the requester not served last wins.
    function automatic logic [1:0] rr_grant(input logic req0, input logic req1, input logic last_id);
        logic [1:0] g;
        if (req0 && req1) begin
            g = (last_id == REQ_M1) ? 2'b01 : 2'b10;
        end else begin
            g = {req1, req0};
        end
        return g;
    endfunction

endpackage

// File: rtl/onchip_memory_arbiter_checker.sv
// Protocol checks for the arbiter: illegal simultaneous read/write and grant exclusivity.
module onchip_memory_arbiter_checker (
    input logic clk,
    input logic reset_n,
    input logic m0_read,
    input logic m0_write,
    input logic m1_read,
    input logic m1_write,
    input logic gnt0,
    input logic gnt1
);

    // A read and a write together is an illegal command; the arbiter executes it as a write.
    a_m0_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(m0_read && m0_write));
    a_m1_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(m1_read && m1_write));
    a_one_grant:  assert property (@(posedge clk) disable iff (!reset_n) !(gnt0 && gnt1));

endmodule

// File: rtl/onchip_memory_arbiter_rdtag_pipe.sv
// Read-tag delay line: one {valid, id} entry per memory cycle, matching the memory read latency.
module onchip_memory_arbiter_rdtag_pipe
    import onchip_memory_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    reset_n,
    input  rd_tag_t push_tag,
    output rd_tag_t pop_tag
);

    rd_tag_t stage_r [DEPTH];

    // Shift one entry per cycle; reset drops every in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign pop_tag = stage_r[DEPTH-1];

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM masters,
// with fixed-latency read data steered back to the issuing master.
module onchip_memory_arbiter
    import onchip_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BE_W         = DEF_BE_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic    req0_s, req1_s;
    logic    gnt0_s, gnt1_s;
    logic    sel_read_s, sel_write_s;
    logic    last_grant_r;
    rd_tag_t push_tag_s, pop_tag_s;

    // Request decode and round-robin grant; nothing is granted while in reset.
    always_comb begin
        req0_s = m0_read | m0_write;
        req1_s = m1_read | m1_write;
        if (!reset_n) begin
            {gnt1_s, gnt0_s} = 2'b00;
        end else begin
            {gnt1_s, gnt0_s} = rr_grant(req0_s, req1_s, last_grant_r);
        end
        m0_waitrequest = ~reset_n | (req0_s & ~gnt0_s);
        m1_waitrequest = ~reset_n | (req1_s & ~gnt1_s);
    end

    // Remember who was served last so a tie alternates; m0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= REQ_M1;
        end else if (gnt0_s || gnt1_s) begin
            last_grant_r <= gnt1_s ? REQ_M1 : REQ_M0;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Memory port mux; idle cycles present m0's fields with the strobes low.
    always_comb begin
        if (gnt1_s) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            sel_write_s    = m1_write;
            sel_read_s     = m1_read;
        end else begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            sel_write_s    = m0_write & gnt0_s;
            sel_read_s     = m0_read & gnt0_s;
        end
        mem_chipselect   = gnt0_s | gnt1_s;
        mem_write        = sel_write_s;
        mem_clken        = reset_n;
        push_tag_s.valid = sel_read_s & ~sel_write_s;
        push_tag_s.id    = gnt1_s ? REQ_M1 : REQ_M0;
    end

    onchip_memory_arbiter_rdtag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_rdtag_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_tag (push_tag_s),
        .pop_tag  (pop_tag_s)
    );

    // Steer the returning read to the requester recorded in its tag.
    always_comb begin
        m0_readdata      = mem_readdata;
        m1_readdata      = mem_readdata;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        if (pop_tag_s.valid) begin
            m0_readdatavalid = (pop_tag_s.id == REQ_M0);
            m1_readdatavalid = (pop_tag_s.id == REQ_M1);
        end else begin
            m0_readdatavalid = 1'b0;
            m1_readdatavalid = 1'b0;
        end
    end

    onchip_memory_arbiter_checker u_checker (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_read  (m0_read),
        .m0_write (m0_write),
        .m1_read  (m1_read),
        .m1_write (m1_write),
        .gnt0     (gnt0_s),
        .gnt1     (gnt1_s)
    );

endmodule
